// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the MEM-stage controller
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic memto_reg;
        logic reg_write;
    } wb_ctrl_t;

    localparam wb_ctrl_t    BUBBLE          = '{memto_reg: 1'b0, reg_write: 1'b0};
    localparam logic [31:0] WORD_MASK       = 32'hFFFF_FFFC;
    localparam int          DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - wait-cycle counter that flags the last permitted BUSY cycle
module mem_timeout_counter
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM-stage controller: data-memory handshake, stall, MEM/WB commit, branch resolve
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] EXE_MEM_Result,
    input  logic [31:0] EXE_MEM_Rt,
    input  logic [31:0] EXE_MEM_BranchAddress,
    input  logic [4:0]  EXE_MEM_DstReg,
    input  logic        EXE_MEM_Zero,
    input  logic        EXE_MEM_BranchEqual,
    input  logic        EXE_MEM_BranchnotEqual,
    input  logic        EXE_MEM_MemRead,
    input  logic        EXE_MEM_MemWrite,
    input  logic        EXE_MEM_MemtoReg,
    input  logic        EXE_MEM_RegWrite,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        PCSrc,
    output logic [31:0] BranchTarget,
    output logic [31:0] MEM_WB_ReadData,
    output logic [31:0] MEM_WB_Result,
    output logic [4:0]  MEM_WB_DstReg,
    output logic        MEM_WB_MemtoReg,
    output logic        MEM_WB_RegWrite,
    output logic        mem_err
);

    state_t   state, state_nxt;
    logic     access, aligned;
    logic     issue, commit, abort, misalign;
    logic     cnt_clear, cnt_en, expire;
    logic [4:0] lat_dst;
    wb_ctrl_t   lat_ctrl;

    assign access  = EXE_MEM_MemRead | EXE_MEM_MemWrite;
    assign aligned = ((EXE_MEM_Result & ~WORD_MASK) == 32'd0);

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        issue     = 1'b0;
        commit    = 1'b0;
        abort     = 1'b0;
        misalign  = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE: begin
                if (access && !aligned) begin
                    misalign = 1'b1;
                end else if (access) begin
                    issue     = 1'b1;
                    mem_stall = 1'b1;
                    cnt_clear = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // An ack on the final permitted cycle still completes the access.
                if (dmem_ack) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end else if (expire) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    mem_stall = 1'b1;
                    cnt_en    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign PCSrc = (state == IDLE) &&
                   ((EXE_MEM_BranchEqual & EXE_MEM_Zero) |
                    (EXE_MEM_BranchnotEqual & ~EXE_MEM_Zero));
    assign BranchTarget = EXE_MEM_BranchAddress;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= 32'd0;
            dmem_wdata      <= 32'd0;
            lat_dst         <= 5'd0;
            lat_ctrl        <= BUBBLE;
            MEM_WB_ReadData <= 32'd0;
            MEM_WB_Result   <= 32'd0;
            MEM_WB_DstReg   <= 5'd0;
            MEM_WB_MemtoReg <= 1'b0;
            MEM_WB_RegWrite <= 1'b0;
            mem_err         <= 1'b0;
        end else begin
            if (issue) begin
                dmem_req   <= 1'b1;
                dmem_we    <= EXE_MEM_MemWrite & ~EXE_MEM_MemRead;
                dmem_addr  <= EXE_MEM_Result & WORD_MASK;
                dmem_wdata <= EXE_MEM_Rt;
                lat_dst    <= EXE_MEM_DstReg;
                lat_ctrl   <= '{memto_reg: EXE_MEM_MemtoReg, reg_write: EXE_MEM_RegWrite};
            end else if (commit || abort) begin
                dmem_req <= 1'b0;
            end

            if (misalign || abort) begin
                mem_err <= 1'b1;
            end

            if (commit) begin
                MEM_WB_ReadData <= dmem_we ? 32'd0 : dmem_rdata;
                MEM_WB_Result   <= dmem_addr;
                MEM_WB_DstReg   <= lat_dst;
                MEM_WB_MemtoReg <= lat_ctrl.memto_reg;
                MEM_WB_RegWrite <= lat_ctrl.reg_write;
            end else if (state == IDLE && !access) begin
                MEM_WB_ReadData <= 32'd0;
                MEM_WB_Result   <= EXE_MEM_Result;
                MEM_WB_DstReg   <= EXE_MEM_DstReg;
                MEM_WB_MemtoReg <= EXE_MEM_MemtoReg;
                MEM_WB_RegWrite <= EXE_MEM_RegWrite;
            end else begin
                // Issue, wait, abort and misaligned cycles all present a bubble.
                MEM_WB_ReadData <= 32'd0;
                MEM_WB_Result   <= 32'd0;
                MEM_WB_DstReg   <= 5'd0;
                MEM_WB_MemtoReg <= BUBBLE.memto_reg;
                MEM_WB_RegWrite <= BUBBLE.reg_write;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] EXE_MEM_Result, EXE_MEM_Rt, EXE_MEM_BranchAddress;
    logic [4:0]  EXE_MEM_DstReg;
    logic        EXE_MEM_Zero, EXE_MEM_BranchEqual, EXE_MEM_BranchnotEqual;
    logic        EXE_MEM_MemRead, EXE_MEM_MemWrite, EXE_MEM_MemtoReg, EXE_MEM_RegWrite;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_stall, PCSrc, mem_err;
    logic [31:0] BranchTarget, MEM_WB_ReadData, MEM_WB_Result;
    logic [4:0]  MEM_WB_DstReg;
    logic        MEM_WB_MemtoReg, MEM_WB_RegWrite;

    int n_vec = 0;
    int n_err = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .EXE_MEM_Result         (EXE_MEM_Result),
        .EXE_MEM_Rt             (EXE_MEM_Rt),
        .EXE_MEM_BranchAddress  (EXE_MEM_BranchAddress),
        .EXE_MEM_DstReg         (EXE_MEM_DstReg),
        .EXE_MEM_Zero           (EXE_MEM_Zero),
        .EXE_MEM_BranchEqual    (EXE_MEM_BranchEqual),
        .EXE_MEM_BranchnotEqual (EXE_MEM_BranchnotEqual),
        .EXE_MEM_MemRead        (EXE_MEM_MemRead),
        .EXE_MEM_MemWrite       (EXE_MEM_MemWrite),
        .EXE_MEM_MemtoReg       (EXE_MEM_MemtoReg),
        .EXE_MEM_RegWrite       (EXE_MEM_RegWrite),
        .dmem_req               (dmem_req),
        .dmem_we                (dmem_we),
        .dmem_addr              (dmem_addr),
        .dmem_wdata             (dmem_wdata),
        .dmem_rdata             (dmem_rdata),
        .dmem_ack               (dmem_ack),
        .mem_stall              (mem_stall),
        .PCSrc                  (PCSrc),
        .BranchTarget           (BranchTarget),
        .MEM_WB_ReadData        (MEM_WB_ReadData),
        .MEM_WB_Result          (MEM_WB_Result),
        .MEM_WB_DstReg          (MEM_WB_DstReg),
        .MEM_WB_MemtoReg        (MEM_WB_MemtoReg),
        .MEM_WB_RegWrite        (MEM_WB_RegWrite),
        .mem_err                (mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_nop();
        EXE_MEM_Result = 32'd0; EXE_MEM_Rt = 32'd0; EXE_MEM_BranchAddress = 32'd0;
        EXE_MEM_DstReg = 5'd0; EXE_MEM_Zero = 1'b0; EXE_MEM_BranchEqual = 1'b0;
        EXE_MEM_BranchnotEqual = 1'b0; EXE_MEM_MemRead = 1'b0; EXE_MEM_MemWrite = 1'b0;
        EXE_MEM_MemtoReg = 1'b0; EXE_MEM_RegWrite = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   32'(dmem_req), 32'd0);
        chk({tag, "_we"},    32'(dmem_we), 32'd0);
        chk({tag, "_addr"},  dmem_addr, 32'd0);
        chk({tag, "_wdata"}, dmem_wdata, 32'd0);
        chk({tag, "_stall"}, 32'(mem_stall), 32'd0);
        chk({tag, "_rdata"}, MEM_WB_ReadData, 32'd0);
        chk({tag, "_res"},   MEM_WB_Result, 32'd0);
        chk({tag, "_dst"},   32'(MEM_WB_DstReg), 32'd0);
        chk({tag, "_m2r"},   32'(MEM_WB_MemtoReg), 32'd0);
        chk({tag, "_rw"},    32'(MEM_WB_RegWrite), 32'd0);
        chk({tag, "_err"},   32'(mem_err), 32'd0);
    endtask

    // One instruction through MEM; k = BUSY cycle (1-based) on which memory acks.
    task automatic run_txn(input logic mr, input logic mw, input logic [31:0] res,
                           input logic [31:0] rt, input logic [31:0] br,
                           input logic [4:0] dst, input logic m2r, input logic rw,
                           input logic beq, input logic bne, input logic zero,
                           input int k, input logic [31:0] rd);
        logic acc, mis, wr, acked, exp_pc;
        logic [31:0] word_addr;
        int n;
        acc       = mr | mw;
        mis       = acc && (res[1:0] != 2'b00);
        wr        = mw & ~mr;
        acked     = (k <= TIMEOUT);
        exp_pc    = (beq & zero) | (bne & ~zero);
        word_addr = res & 32'hFFFF_FFFC;
        n         = (acc && !mis) ? (acked ? k : TIMEOUT) : 0;
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            if (c == 0) begin
                EXE_MEM_Result = res; EXE_MEM_Rt = rt; EXE_MEM_BranchAddress = br;
                EXE_MEM_DstReg = dst; EXE_MEM_Zero = zero; EXE_MEM_BranchEqual = beq;
                EXE_MEM_BranchnotEqual = bne; EXE_MEM_MemRead = mr; EXE_MEM_MemWrite = mw;
                EXE_MEM_MemtoReg = m2r; EXE_MEM_RegWrite = rw;
            end else begin
                EXE_MEM_Result = $urandom;
                EXE_MEM_Rt     = $urandom;
                EXE_MEM_DstReg = 5'($urandom);
            end
            dmem_ack   = (n > 0) && (c == n) && acked;
            dmem_rdata = dmem_ack ? rd : $urandom;
            #1;
            chk("stall", 32'(mem_stall), 32'((acc && !mis) ? (c < n) : 1'b0));
            chk("req", 32'(dmem_req), 32'(c >= 1));
            if (c >= 1) begin
                chk("we", 32'(dmem_we), 32'(wr));
                chk("addr", dmem_addr, word_addr);
                chk("wdata", dmem_wdata, rt);
            end
            chk("pcsrc", 32'(PCSrc), 32'((c == 0) ? exp_pc : 1'b0));
            chk("target", BranchTarget, br);
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            if (!acc) begin
                chk("wb_res", MEM_WB_Result, res);
                chk("wb_rdata", MEM_WB_ReadData, 32'd0);
                chk("wb_dst", 32'(MEM_WB_DstReg), 32'(dst));
                chk("wb_m2r", 32'(MEM_WB_MemtoReg), 32'(m2r));
                chk("wb_rw", 32'(MEM_WB_RegWrite), 32'(rw));
            end else if (c == n && n > 0 && acked) begin
                chk("wb_res", MEM_WB_Result, word_addr);
                chk("wb_rdata", MEM_WB_ReadData, wr ? 32'd0 : rd);
                chk("wb_dst", 32'(MEM_WB_DstReg), 32'(dst));
                chk("wb_m2r", 32'(MEM_WB_MemtoReg), 32'(m2r));
                chk("wb_rw", 32'(MEM_WB_RegWrite), 32'(rw));
            end else begin
                chk("bubble_m2r", 32'(MEM_WB_MemtoReg), 32'd0);
                chk("bubble_rw", 32'(MEM_WB_RegWrite), 32'd0);
            end
            if (mis || (n > 0 && c == n && !acked)) exp_err = 1'b1;
            chk("err", 32'(mem_err), 32'(exp_err));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        drive_nop();
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ALU op, LW with 3-cycle latency, immediate-ack SW
        run_txn(0, 0, 32'h10, 32'h0, 32'h0, 5'd5, 0, 1, 0, 0, 0, 0, 32'h0);
        run_txn(1, 0, 32'h100, 32'h0, 32'h0, 5'd3, 1, 1, 0, 0, 0, 3, 32'hCAFEBABE);
        run_txn(0, 1, 32'h204, 32'h12345678, 32'h0, 5'd0, 0, 0, 0, 0, 0, 1, 32'h0);
        // ack on the last allowed cycle, then misaligned and timed-out loads
        run_txn(1, 0, 32'h300, 32'h0, 32'h0, 5'd7, 1, 1, 0, 0, 0, TIMEOUT, 32'h0BADF00D);
        run_txn(1, 0, 32'h102, 32'h0, 32'h0, 5'd4, 1, 1, 0, 0, 0, 1, 32'h0);
        run_txn(1, 0, 32'h400, 32'h0, 32'h0, 5'd6, 1, 1, 0, 0, 0, 100, 32'h0);
        // branches, including one riding on a load so PCSrc must drop while BUSY
        run_txn(0, 0, 32'h0, 32'h0, 32'h40, 5'd0, 0, 0, 1, 0, 1, 0, 32'h0);
        run_txn(0, 0, 32'h0, 32'h0, 32'h80, 5'd0, 0, 0, 0, 1, 1, 0, 32'h0);
        run_txn(1, 1, 32'h500, 32'h5, 32'hC0, 5'd9, 1, 1, 1, 0, 1, 2, 32'h11223344);

        // reset while an access is outstanding, then a stale ack
        @(negedge clk);
        EXE_MEM_Result = 32'h600; EXE_MEM_MemRead = 1'b1; EXE_MEM_RegWrite = 1'b1;
        EXE_MEM_MemtoReg = 1'b1; EXE_MEM_DstReg = 5'd8;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("busy_req", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        drive_nop();
        exp_err = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("stale_stall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        chk("stale_rw", 32'(MEM_WB_RegWrite), 32'd0);
        chk("stale_rdata", MEM_WB_ReadData, 32'd0);
        chk("stale_req", 32'(dmem_req), 32'd0);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] res;
            int kind;
            kind = $urandom_range(0, 3);
            res  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) res[1:0] = 2'($urandom_range(1, 3));
            run_txn(kind[0], kind[1], res, $urandom, $urandom, 5'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(1, TIMEOUT + 4), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
